// File: rtl/pattern_hflipper_pkg.sv
// pattern_hflipper_pkg: shared pattern-line geometry, line type and pixel-reverse helper.
package pattern_hflipper_pkg;
  localparam int PATTERN_PX  = 8;
  localparam int PATTERN_BPP = 2;
  localparam int PATTERN_W   = PATTERN_PX * PATTERN_BPP;
  typedef logic [PATTERN_W-1:0] pattern_line_t;
  // Reverses pixel order while keeping the bit order inside each pixel.
  function automatic pattern_line_t pixel_reverse(input pattern_line_t l);
    pattern_line_t r;
    r = '0;
    for (int i = 0; i < PATTERN_PX; i++)
      r[i*PATTERN_BPP +: PATTERN_BPP] = l[(PATTERN_PX-1-i)*PATTERN_BPP +: PATTERN_BPP];
    return r;
  endfunction
endpackage

// File: rtl/pattern_hflipper_if.sv
// pattern_hflipper_if: line-in / mirrored-line-out bus.
//   in_valid/in_line/in_hflip : request from master
//   out_valid/out_line/out_mask : registered result from slave
interface pattern_hflipper_if
  import pattern_hflipper_pkg::*;
#(
  parameter int PX  = PATTERN_PX,
  parameter int BPP = PATTERN_BPP
);
  logic              in_valid;
  logic [PX*BPP-1:0] in_line;
  logic              in_hflip;
  logic              out_valid;
  logic [PX*BPP-1:0] out_line;
  logic [PX-1:0]     out_mask;
  modport master (output in_valid, in_line, in_hflip, input out_valid, out_line, out_mask);
  modport slave  (input in_valid, in_line, in_hflip, output out_valid, out_line, out_mask);
endinterface

// File: rtl/pattern_hflipper.sv
// pattern_hflipper: optionally mirrors a pattern line horizontally, one-cycle latency, with opacity mask.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : slave side of pattern_hflipper_if (in_valid/in_line/in_hflip -> out_valid/out_line/out_mask)
module pattern_hflipper
  import pattern_hflipper_pkg::*;
#(
  parameter int PX  = PATTERN_PX,
  parameter int BPP = PATTERN_BPP
) (
  input logic               clk,
  input logic               rst,
  pattern_hflipper_if.slave bus
);
  localparam int W = PX * BPP;
  logic [W-1:0]  flip_d, line_d, line_q;
  logic [PX-1:0] mask_d, mask_q;
  logic          valid_q;
  for (genvar i = 0; i < PX; i++) begin : g_px
    assign flip_d[i*BPP +: BPP] = bus.in_line[(PX-1-i)*BPP +: BPP];
    // Mask follows the (possibly mirrored) output ordering, not the input.
    assign mask_d[i] = |line_d[i*BPP +: BPP];
  end
  assign line_d = bus.in_hflip ? flip_d : bus.in_line;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      line_q  <= '0;
      mask_q  <= '0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        line_q <= line_d;
        mask_q <= mask_d;
      end
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.out_line  = line_q;
  assign bus.out_mask  = mask_q;
endmodule

// File: tb/tb_pattern_hflipper.sv
// tb_pattern_hflipper: scoreboard bench with pixel-level reference model and random sweep.
module tb_pattern_hflipper;
  import pattern_hflipper_pkg::*;
  localparam int PX  = PATTERN_PX;
  localparam int BPP = PATTERN_BPP;
  localparam int W   = PX * BPP;
  typedef struct packed {
    logic [W-1:0]  line;
    logic [PX-1:0] mask;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int passes = 0;
  exp_t q[$];
  logic exp_valid = 1'b0;
  exp_t hold = '0;
  pattern_hflipper_if #(.PX(PX), .BPP(BPP)) bus ();
  pattern_hflipper #(.PX(PX), .BPP(BPP)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // Reference: pixel p sits at the MSB end for p=0; mirror swaps pixel k with PX-1-k.
  function automatic exp_t model(input logic [W-1:0] l, input logic hf);
    logic [BPP-1:0] px [PX];
    exp_t e;
    e = '0;
    for (int p = 0; p < PX; p++) px[p] = l[W-1-p*BPP -: BPP];
    for (int k = 0; k < PX; k++) e.line[W-1-k*BPP -: BPP] = hf ? px[PX-1-k] : px[k];
    for (int k = 0; k < PX; k++) e.mask[PX-1-k] = (e.line[W-1-k*BPP -: BPP] != '0);
    return e;
  endfunction
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic drive(input logic v, input logic [W-1:0] l, input logic hf);
    bus.in_valid = v;
    bus.in_line  = l;
    bus.in_hflip = hf;
    @(posedge clk);
    exp_valid = v;
    if (v) begin
      hold = model(l, hf);
      q.push_back(hold);
    end
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (rst) begin
      chk("out_valid", W'(bus.out_valid), W'(exp_valid));
      if (bus.out_valid) begin
        chk("sb_nonempty", W'(q.size() != 0), W'(1));
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("sb_line", bus.out_line, e.line);
          chk("sb_mask", W'(bus.out_mask), W'(e.mask));
        end
      end else begin
        chk("hold_line", bus.out_line, hold.line);
        chk("hold_mask", W'(bus.out_mask), W'(hold.mask));
      end
    end
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_line  = '0;
    bus.in_hflip = 1'b0;
    #1;
    chk("rst_valid", W'(bus.out_valid), '0);
    chk("rst_line", bus.out_line, '0);
    chk("rst_mask", W'(bus.out_mask), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    drive(1'b1, 16'hE400, 1'b0);
    #1;
    chk("e400_line", bus.out_line, 16'hE400);
    chk("e400_mask", W'(bus.out_mask), 16'h00E0);
    chk("e400_valid", W'(bus.out_valid), W'(1));
    drive(1'b1, 16'hE400, 1'b1);
    #1;
    chk("e400f_line", bus.out_line, 16'h001B);
    chk("e400f_mask", W'(bus.out_mask), 16'h0007);
    drive(1'b1, 16'hFFFF, 1'b0);
    #1;
    chk("ffff0_line", bus.out_line, 16'hFFFF);
    chk("ffff0_mask", W'(bus.out_mask), 16'h00FF);
    drive(1'b1, 16'hFFFF, 1'b1);
    #1;
    chk("ffff1_line", bus.out_line, 16'hFFFF);
    chk("ffff1_valid", W'(bus.out_valid), W'(1));
    drive(1'b1, 16'hC003, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h1234, 1'b0);
      #1;
      chk("c003_hold_line", bus.out_line, 16'hC003);
      chk("c003_hold_mask", W'(bus.out_mask), 16'h0081);
      chk("c003_hold_valid", W'(bus.out_valid), '0);
    end
    drive(1'b1, 16'hA5C3, 1'b1);
    #2 rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_line  = 16'h5A5A;
    #1;
    chk("async_valid", W'(bus.out_valid), '0);
    chk("async_line", bus.out_line, '0);
    chk("async_mask", W'(bus.out_mask), '0);
    q.delete();
    exp_valid = 1'b0;
    hold = '0;
    @(posedge clk);
    #1;
    chk("inrst_valid", W'(bus.out_valid), '0);
    chk("inrst_line", bus.out_line, '0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 16'h7777, 1'b1);
    drive(1'b1, 16'h1B00, 1'b1);
    for (int i = 0; i < 10000; i++)
      drive(logic'($urandom_range(0, 9) < 8), W'($urandom), 1'($urandom));
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("sb_drained", W'(q.size()), '0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pattern_hflipper.md
PATTERN_HFLIPPER -- requirements
Module: pattern_hflipper

Interface
REQ-001 Parameter PX, default 8, pixels per pattern line.
REQ-002 Parameter BPP, default 2, bits per pixel; line width W = PX*BPP (16 by default).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 in_valid  input  1  qualifies in_line/in_hflip this cycle.
REQ-006 in_line  input  W  pattern line; pixel 0 (leftmost) = bits [W-1:W-BPP], pixel PX-1 = bits [BPP-1:0].
REQ-007 in_hflip  input  1  1 = mirror line horizontally.
REQ-008 out_valid  output  1  out_line/out_mask hold a result captured from a valid input.
REQ-009 out_line  output  W  possibly-mirrored line, same pixel ordering as in_line.
REQ-010 out_mask  output  PX  out_mask[i] = 1 iff out_line[i*BPP+BPP-1 : i*BPP] != 0 (opaque pixel).

Function
REQ-011 Mirror rule: with in_hflip=1, out pixel k SHALL equal in pixel PX-1-k for all k; bit order inside a pixel is preserved (pixels reversed, not bits).
REQ-012 With in_hflip=0, out_line SHALL equal in_line.
REQ-013 Latency exactly 1 cycle: inputs sampled at edge N appear on outputs after edge N.
REQ-014 out_line/out_mask registers load only when in_valid=1; when in_valid=0 they hold last value.
REQ-015 out_valid SHALL be a registered copy of in_valid (1 cycle later), no backpressure, no ready signal.
REQ-016 out_mask SHALL be computed from the mirrored line, registered in the same cycle as out_line (never from in_line ordering).
REQ-017 Pixel value 0 SHALL be transparent; any nonzero value opaque.
REQ-018 Back-to-back valid inputs SHALL be accepted every cycle at full throughput.
REQ-019 Palindromic lines produce identical out_line for either in_hflip value.
REQ-020 No combinational path from any input to any output.

Reset
REQ-021 While rst=0: out_valid=0, out_line=0, out_mask=0, immediately (asynchronous).
REQ-022 Reset deassertion mid-stream: first input sampled is the one present at the first rising edge with rst=1; no stale data or spurious out_valid.

Structure
REQ-023 Shared package SHALL hold PATTERN_PX=8, PATTERN_BPP=2, the line type and a pure pixel-reverse function reused by the foreground renderer.
REQ-024 Single module, no sub-modules; mask generation as a generate loop over pixels.
REQ-025 Parameters SHALL be honoured generically (e.g. PX=16, BPP=4) with no hardcoded widths.

Verification
REQ-026 in_line=0xE400, in_hflip=0, in_valid=1 -> next cycle out_line=0xE400, out_mask=0xE0, out_valid=1.
REQ-027 in_line=0xE400, in_hflip=1 -> out_line=0x001B, out_mask=0x07.
REQ-028 in_line=0xFFFF with hflip 0 then 1 on consecutive cycles -> out_line=0xFFFF both cycles, out_mask=0xFF, out_valid high 2 cycles.
REQ-029 Valid 0xC003 hflip=1, then in_valid=0 for 3 cycles with in_line=0x1234 -> out_line stays 0xC003, out_mask=0x81, out_valid=0 after first cycle.
REQ-030 Assert rst=0 between edges while out_valid=1 -> outputs zero immediately, before next edge; release -> resumes per REQ-022.
REQ-031 Random sweep of 10000 lines/hflip vs. reference model of REQ-011/REQ-010 -> zero mismatches.
